mc_cpu_core: RTL and testbench
==============================

# mc_cpu_core

Parametrised multicycle CPU core, successor to the fixed 8-bit, 2-register multicycle CPU. Data width, address width and register count are parameters. It drives a single unified instruction/data memory port through a req/ready handshake that tolerates any memory latency. It adds a retired-instruction counter and an illegal-opcode trap, and is instantiated at the top of the processor subsystem in place of the old core.

## Interface
- DATA_W, 16, register/ALU/memory word width; legal range is 16 or more
- ADDR_W, 8, memory address width; PC width
- NREGS, 4, number of general registers; power of 2, 2..16
- CNT_W, 16, width of the retired-instruction counter
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  out  ADDR_W  transfer address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data; sampled on the edge where mem_ready is high
- mem_ready  in  1  transfer completes on the edge where mem_req and mem_ready are both high
- halted  out  1  core stopped by HALT or trap
- trap  out  1  sticky; set when an illegal opcode is executed
- instr_count  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W

## Operation
- Instruction format: the low 16 bits of the fetched word.
  - op = [15:12]
  - rd = [11:8]
  - rs = [7:4]
  - imm8 = [7:0]
  - off4 = [3:0]
  - Register indices use the low log2(NREGS) bits of their field.
- Opcodes:
  - 0 NAND: rd = ~(rd & rs)
  - 1 ADD: rd = rd + rs
  - 2 ADDM: rd = rd + mem[rs]
  - 3 ADDI: rd = rd + zext(imm8)
  - 4 SUB: rd = rd - rs
  - 5 MUL: rd = low DATA_W bits of rd*rs
  - 6 LD: rd = mem[rs]
  - 7 ST: mem[rs] = rd
  - 8 BEQ: if rd == rs then PC = PC + sext(off4)
  - 9 JMP: PC = PC + sext(imm8)
  - F HALT
  - A-E: illegal
- Arithmetic: all results truncated to DATA_W, no flags. Memory addresses use the low ADDR_W bits of rs.
- Branch arithmetic:
  - PC already points to the next instruction, so the branch target is instr_addr + 1 + offset.
  - PC arithmetic wraps modulo 2^ADDR_W.
- FSM states: IDLE, FETCH, EXEC, MEM, ADDM, HALT.
- IDLE (the reset state):
  - All outputs 0.
  - Goes to FETCH unconditionally.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=PC.
  - On ready: IR <= rdata[15:0], PC <= PC+1, go to EXEC.
- EXEC:
  - ALU ops, ADDI, BEQ and JMP commit, then go to FETCH.
  - LD, ST and ADDM go to MEM.
  - HALT goes to HALT.
  - Illegal opcode: trap <= 1, go to HALT.
- MEM:
  - Drives mem_req=1, mem_addr=rs[ADDR_W-1:0], mem_we=(op==ST), mem_wdata=rd.
  - On ready: LD writes rd and goes to FETCH; ST goes to FETCH.
  - ADDM latches rdata into an operand register and goes to ADDM.
- ADDM: rd <= rd + operand, then go to FETCH.
- HALT:
  - Terminal; halted=1, mem_req=0.
  - Leaves only on reset.
- instr_count:
  - Increments by 1 when an instruction completes: the EXEC, MEM or ADDM exit to FETCH, or EXEC→HALT on the HALT opcode.
  - The trapping instruction is not counted.
- Reset values:
  - PC, IR, all registers, instr_count, trap and halted are 0.
  - State is IDLE.
  - All mem_* outputs are 0.

## Timing
- mem_req is a Moore output of the state; it is never high in IDLE, EXEC, ADDM or HALT.
- While mem_req is high, mem_addr, mem_we and mem_wdata are held stable until the ready edge.
- mem_ready while mem_req is low is ignored.
- Minimum latencies with zero memory wait, counted from fetch-request cycle to next fetch-request cycle:
  - ALU, ADDI, branch: 2 cycles.
  - LD, ST: 3 cycles.
  - ADDM: 4 cycles.
- Each memory wait cycle adds 1 cycle; there is no timeout.
- The register write and PC update for an instruction land on the same edge as the state exit.
- A mid-transfer reset_n assertion immediately forces IDLE with mem_req=0; the outstanding transfer is abandoned.
- First mem_req after reset release appears in the second cycle: IDLE, then FETCH.

## Test plan
- Zero-wait memory with program ADDI r1,5; ADDI r2,3; MUL r1,r2; HALT -> r1=15, halted=1, instr_count=4, trap=0, 8 cycles from first fetch to halted.
- The same program with mem_ready delayed 3 cycles on every transfer -> same final state; mem_addr and mem_req stable through each wait.
- Test ST then LD: r1=0x1234, r2=0x40 (store address), then ST r1,r2; LD r3,r2 -> write of 0x1234 at address 0x40 seen with mem_we=1, r3=0x1234; then ADDM r3,r2 -> r3=0x2468.
- BEQ taken at address 0x10 with off4=0xE (-2) -> next fetch at 0x0F; with rd≠rs -> next fetch at 0x11; JMP at 0xFF with imm8=0x01 -> fetch at 0x01 (wrap).
- Opcode 0xB at address 3 -> trap=1, halted=1, instr_count=3, mem_req stays 0 permanently.
- Assert reset_n low during a MEM-state wait -> mem_req drops the same cycle, all registers and counters are 0, fetch restarts at PC=0.

Source files
------------

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: parametrised multicycle CPU core with a unified req/ready
// memory port, a retired-instruction counter and an illegal-opcode trap.
// Each instruction walks FETCH -> EXEC [-> MEM [-> ADDM]] and then returns
// to FETCH. The memory port is a Moore function of the state, so it stays
// stable for any number of wait cycles.
module mc_cpu_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              trap,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [3:0] OP_NAND = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADDM = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_ADDM,
    S_HALT
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] operand;

  // Instruction fields; only the low RIDX_W bits of each register field
  // select a register, the rest are deliberately ignored.
  logic [3:0]        op;
  logic [3:0]        rd_field;
  logic [3:0]        rs_field;
  logic [7:0]        imm8;
  logic [3:0]        off4;
  logic [RIDX_W-1:0] rd_idx;
  logic [RIDX_W-1:0] rs_idx;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic              unused_fields;

  assign op            = ir[15:12];
  assign rd_field      = ir[11:8];
  assign rs_field      = ir[7:4];
  assign imm8          = ir[7:0];
  assign off4          = ir[3:0];
  assign rd_idx        = rd_field[RIDX_W-1:0];
  assign rs_idx        = rs_field[RIDX_W-1:0];
  assign rd_val        = regs[rd_idx];
  assign rs_val        = regs[rs_idx];
  assign unused_fields = ^{rd_field, rs_field};

  // Sign-extend a 4-bit branch offset to PC width.
  function automatic logic [ADDR_W-1:0] sext_off4(input logic [3:0] v);
    logic signed [3:0] s;
    s = v;
    return ADDR_W'(s);
  endfunction

  // Sign-extend an 8-bit jump offset to PC width.
  function automatic logic [ADDR_W-1:0] sext_imm8(input logic [7:0] v);
    logic signed [7:0] s;
    s = v;
    return ADDR_W'(s);
  endfunction

  // Opcode classes used by both the FSM and the datapath.
  logic is_alu;
  logic is_illegal;
  logic is_memop;

  assign is_alu     = (op == OP_NAND) || (op == OP_ADD) || (op == OP_ADDI) ||
                      (op == OP_SUB)  || (op == OP_MUL);
  assign is_memop   = (op == OP_LD) || (op == OP_ST) || (op == OP_ADDM);
  assign is_illegal = (op >= 4'hA) && (op <= 4'hE);

  // Register-to-register ALU result, truncated to DATA_W.
  logic [DATA_W-1:0] alu_res;

  // ALU: combinational result for the single-cycle arithmetic opcodes.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_NAND: alu_res = ~(rd_val & rs_val);
      OP_ADD:  alu_res = rd_val + rs_val;
      OP_ADDI: alu_res = rd_val + DATA_W'(imm8);
      OP_SUB:  alu_res = rd_val - rs_val;
      OP_MUL:  alu_res = rd_val * rs_val;
      default: alu_res = '0;
    endcase
  end

  // An instruction retires on its exit to FETCH, or on EXEC->HALT for the
  // HALT opcode; a trapping opcode never retires.
  logic retire;

  assign retire = ((state == S_EXEC) && (is_alu || (op == OP_BEQ) ||
                                         (op == OP_JMP) || (op == OP_HALT))) ||
                  ((state == S_MEM) && mem_ready &&
                   ((op == OP_LD) || (op == OP_ST))) ||
                  (state == S_ADDM);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic and Moore memory-port outputs.
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    halted     = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) next_state = S_EXEC;
      end
      S_EXEC: begin
        if (is_memop)                      next_state = S_MEM;
        else if (is_illegal || op == OP_HALT) next_state = S_HALT;
        else                               next_state = S_FETCH;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_W'(rs_val);
        if (op == OP_ST) begin
          mem_we    = 1'b1;
          mem_wdata = rd_val;
        end
        if (mem_ready) next_state = (op == OP_ADDM) ? S_ADDM : S_FETCH;
      end
      S_ADDM: next_state = S_FETCH;
      S_HALT: halted = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: PC, IR, register file, ADDM operand, trap flag and counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= '0;
      ir          <= '0;
      operand     <= '0;
      trap        <= 1'b0;
      instr_count <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (retire) instr_count <= instr_count + CNT_W'(1);
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata[15:0];
            pc <= pc + ADDR_W'(1);
          end
        end
        S_EXEC: begin
          if (is_alu) regs[rd_idx] <= alu_res;
          else if (op == OP_BEQ) begin
            if (rd_val == rs_val) pc <= pc + sext_off4(off4);
          end
          else if (op == OP_JMP) pc <= pc + sext_imm8(imm8);
          else if (is_illegal) trap <= 1'b1;
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op == OP_LD)   regs[rd_idx] <= mem_rdata;
            if (op == OP_ADDM) operand <= mem_rdata;
          end
        end
        S_ADDM: regs[rd_idx] <= rd_val + operand;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Self-checking bench for mc_cpu_core: a behavioural memory with programmable
// wait states logs every completed transfer; each test pushes the transfers
// it expects and drains both queues against each other.
module tb_mc_cpu_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        halted;
  logic        trap;
  logic [15:0] instr_count;

  mc_cpu_core #(.DATA_W(16), .ADDR_W(8), .NREGS(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .trap(trap), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          cyc;
  } xfer_t;

  xfer_t       obs_q[$];
  xfer_t       exp_q[$];
  xfer_t       cur;
  logic [15:0] mem [256];
  int          wait_cycles = 0;
  int          wait_cnt = 0;
  logic        in_xfer = 1'b0;
  int          unstable = 0;
  int          cyc = 0;
  int          first_req_cyc = -1;
  int          halt_cyc = -1;
  int          n_cmp = 0;
  int          n_err = 0;

  // Memory responder: wait states, stability monitoring, transfer logging.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (halted && halt_cyc < 0) halt_cyc = cyc;
    mem_ready = 1'b0;
    if (mem_req) begin
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (in_xfer) begin
        if (mem_addr !== cur.addr || mem_we !== cur.we || mem_wdata !== cur.wdata)
          unstable = unstable + 1;
      end else begin
        in_xfer   = 1'b1;
        cur.we    = mem_we;
        cur.addr  = mem_addr;
        cur.wdata = mem_wdata;
        cur.cyc   = cyc;
        wait_cnt  = 0;
      end
      if (wait_cnt < wait_cycles) wait_cnt = wait_cnt + 1;
      else begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        obs_q.push_back(cur);
        in_xfer = 1'b0;
      end
    end else begin
      in_xfer   = 1'b0;
      mem_rdata = '0;
    end
  end

  task automatic expect_x(input logic we, input logic [7:0] a, input logic [15:0] d);
    xfer_t e;
    e.we = we; e.addr = a; e.wdata = d; e.cyc = 0;
    exp_q.push_back(e);
  endtask

  task automatic hold_reset(input int waits);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    obs_q.delete();
    exp_q.delete();
    wait_cycles   = waits;
    unstable      = 0;
    first_req_cyc = -1;
    halt_cyc      = -1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 600; i++) begin
      if (halted) break;
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (halted !== 1'b1) begin
      n_err++; $display("FAIL halt_timeout: halted=%b required 1", halted);
    end
  endtask

  task automatic test_reset();
    hold_reset(0);
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 26'h0) begin
      n_err++; $display("FAIL reset_mem_port: req=%b we=%b addr=%h wdata=%h required all 0",
                        mem_req, mem_we, mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({halted, trap, instr_count} !== 18'h0) begin
      n_err++; $display("FAIL reset_status: halted=%b trap=%b count=%0d required 0/0/0",
                        halted, trap, instr_count);
    end
    mem[0] = 16'hF000;
    release_reset();
    #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: mem_req=%b required 0 in IDLE", mem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL reset_first_fetch: req=%b addr=%h we=%b required 1/00/0",
                        mem_req, mem_addr, mem_we);
    end
    wait_halt();
    n_cmp++;
    if (instr_count !== 16'd1) begin
      n_err++; $display("FAIL reset_halt_count: count=%0d required 1", instr_count);
    end
  endtask

  task automatic test_program(input int waits);
    xfer_t e, o;
    hold_reset(waits);
    mem[0] = 16'h3105;  // ADDI r1,5
    mem[1] = 16'h3203;  // ADDI r2,3
    mem[2] = 16'h5120;  // MUL  r1,r2
    mem[3] = 16'hF000;  // HALT
    for (int i = 0; i < 4; i++) expect_x(1'b0, 8'(i), 16'h0);
    release_reset();
    wait_halt();
    n_cmp++;
    if (dut.regs[1] !== 16'd15) begin
      n_err++; $display("FAIL prog_r1 (wait %0d): r1=%0d required 15", waits, dut.regs[1]);
    end
    n_cmp++;
    if (instr_count !== 16'd4 || trap !== 1'b0) begin
      n_err++; $display("FAIL prog_status (wait %0d): count=%0d trap=%b required 4/0",
                        waits, instr_count, trap);
    end
    n_cmp++;
    if (halt_cyc - first_req_cyc !== 8 + 4 * waits) begin
      n_err++; $display("FAIL prog_latency (wait %0d): %0d cycles required %0d",
                        waits, halt_cyc - first_req_cyc, 8 + 4 * waits);
    end
    n_cmp++;
    if (unstable !== 0) begin
      n_err++; $display("FAIL prog_stable (wait %0d): %0d unstable cycles required 0", waits, unstable);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL prog_xfer: missing transfer, required addr %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.addr !== e.addr || o.wdata !== e.wdata) begin
          n_err++; $display("FAIL prog_xfer: we=%b addr=%h wdata=%h required %b/%h/%h",
                            o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++; $display("FAIL prog_extra: %0d extra transfers required 0", obs_q.size());
    end
  endtask

  task automatic test_load_store();
    xfer_t e, o;
    hold_reset(0);
    mem[8'h50] = 16'h1234;
    mem[0] = 16'h3350;  // ADDI r3,0x50
    mem[1] = 16'h6130;  // LD   r1,r3
    mem[2] = 16'h3240;  // ADDI r2,0x40
    mem[3] = 16'h7120;  // ST   r1,r2
    mem[4] = 16'h6320;  // LD   r3,r2
    mem[5] = 16'h2320;  // ADDM r3,r2
    mem[6] = 16'h7320;  // ST   r3,r2
    mem[7] = 16'hF000;  // HALT
    expect_x(1'b0, 8'h00, 16'h0);
    expect_x(1'b0, 8'h01, 16'h0); expect_x(1'b0, 8'h50, 16'h0);
    expect_x(1'b0, 8'h02, 16'h0);
    expect_x(1'b0, 8'h03, 16'h0); expect_x(1'b1, 8'h40, 16'h1234);
    expect_x(1'b0, 8'h04, 16'h0); expect_x(1'b0, 8'h40, 16'h0);
    expect_x(1'b0, 8'h05, 16'h0); expect_x(1'b0, 8'h40, 16'h0);
    expect_x(1'b0, 8'h06, 16'h0); expect_x(1'b1, 8'h40, 16'h2468);
    expect_x(1'b0, 8'h07, 16'h0);
    release_reset();
    wait_halt();
    n_cmp++;
    if (dut.regs[3] !== 16'h2468 || dut.regs[1] !== 16'h1234) begin
      n_err++; $display("FAIL ldst_regs: r1=%h r3=%h required 1234/2468", dut.regs[1], dut.regs[3]);
    end
    n_cmp++;
    if (instr_count !== 16'd8) begin
      n_err++; $display("FAIL ldst_count: count=%0d required 8", instr_count);
    end
    n_cmp++;
    if (halt_cyc - first_req_cyc !== 22) begin
      n_err++; $display("FAIL ldst_latency: %0d cycles required 22", halt_cyc - first_req_cyc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL ldst_xfer: missing transfer, required addr %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.addr !== e.addr || o.wdata !== e.wdata) begin
          n_err++; $display("FAIL ldst_xfer: we=%b addr=%h wdata=%h required %b/%h/%h",
                            o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++; $display("FAIL ldst_extra: %0d extra transfers required 0", obs_q.size());
    end
  endtask

  task automatic test_branch();
    xfer_t e, o;
    hold_reset(0);
    mem[8'h00] = 16'h900F;  // JMP +15   -> 0x10
    mem[8'h10] = 16'h812E;  // BEQ r1,r2,-2 -> 0x0F when equal
    mem[8'h0F] = 16'h3101;  // ADDI r1,1
    mem[8'h11] = 16'h90ED;  // JMP -19   -> 0xFF
    mem[8'hFF] = 16'h9001;  // JMP +1    -> 0x01 (wraps)
    mem[8'h01] = 16'hF000;  // HALT
    expect_x(1'b0, 8'h00, 16'h0); expect_x(1'b0, 8'h10, 16'h0);
    expect_x(1'b0, 8'h0F, 16'h0); expect_x(1'b0, 8'h10, 16'h0);
    expect_x(1'b0, 8'h11, 16'h0); expect_x(1'b0, 8'hFF, 16'h0);
    expect_x(1'b0, 8'h01, 16'h0);
    release_reset();
    wait_halt();
    n_cmp++;
    if (instr_count !== 16'd7) begin
      n_err++; $display("FAIL branch_count: count=%0d required 7", instr_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL branch_fetch: missing transfer, required addr %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.addr !== e.addr) begin
          n_err++; $display("FAIL branch_fetch: we=%b addr=%h required %b/%h",
                            o.we, o.addr, e.we, e.addr);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++; $display("FAIL branch_extra: %0d extra transfers required 0", obs_q.size());
    end
  endtask

  task automatic test_trap();
    xfer_t e, o;
    logic  saw_req;
    hold_reset(1);
    mem[0] = 16'h3101; mem[1] = 16'h3101; mem[2] = 16'h3101;
    mem[3] = 16'hB000;  // illegal opcode
    mem[4] = 16'h3101;
    for (int i = 0; i < 4; i++) expect_x(1'b0, 8'(i), 16'h0);
    release_reset();
    wait_halt();
    n_cmp++;
    if (trap !== 1'b1 || instr_count !== 16'd3 || dut.regs[1] !== 16'd3) begin
      n_err++; $display("FAIL trap_status: trap=%b count=%0d r1=%0d required 1/3/3",
                        trap, instr_count, dut.regs[1]);
    end
    saw_req = 1'b0;
    repeat (30) begin
      @(negedge clk);
      saw_req = saw_req | mem_req;
    end
    n_cmp++;
    if (saw_req !== 1'b0 || halted !== 1'b1 || trap !== 1'b1) begin
      n_err++; $display("FAIL trap_sticky: saw_req=%b halted=%b trap=%b required 0/1/1",
                        saw_req, halted, trap);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL trap_fetch: missing transfer, required addr %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.addr !== e.addr) begin
          n_err++; $display("FAIL trap_fetch: we=%b addr=%h required %b/%h",
                            o.we, o.addr, e.we, e.addr);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++; $display("FAIL trap_extra: %0d extra transfers required 0", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_transfer();
    xfer_t e, o;
    logic  found;
    hold_reset(5);
    mem[0] = 16'h3240;  // ADDI r2,0x40
    mem[1] = 16'h6120;  // LD   r1,r2
    mem[2] = 16'hF000;  // HALT
    mem[8'h40] = 16'hBEEF;
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'h40) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (found !== 1'b1 || instr_count !== 16'd1) begin
      n_err++; $display("FAIL midrst_reach: found=%b count=%0d required 1/1", found, instr_count);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || instr_count !== 16'd0 || dut.pc !== 8'h00) begin
      n_err++; $display("FAIL midrst_clear: req=%b count=%0d pc=%h required 0/0/00",
                        mem_req, instr_count, dut.pc);
    end
    for (int r = 0; r < 4; r++) begin
      n_cmp++;
      if (dut.regs[r] !== 16'h0) begin
        n_err++; $display("FAIL midrst_reg%0d: %h required 0000", r, dut.regs[r]);
      end
    end
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    wait_cycles   = 0;
    first_req_cyc = -1;
    halt_cyc      = -1;
    expect_x(1'b0, 8'h00, 16'h0); expect_x(1'b0, 8'h01, 16'h0);
    expect_x(1'b0, 8'h40, 16'h0); expect_x(1'b0, 8'h02, 16'h0);
    release_reset();
    wait_halt();
    n_cmp++;
    if (dut.regs[1] !== 16'hBEEF || instr_count !== 16'd3) begin
      n_err++; $display("FAIL midrst_rerun: r1=%h count=%0d required BEEF/3", dut.regs[1], instr_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL midrst_xfer: missing transfer, required addr %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.addr !== e.addr) begin
          n_err++; $display("FAIL midrst_xfer: we=%b addr=%h required %b/%h",
                            o.we, o.addr, e.we, e.addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_program(0);
    test_program(3);
    test_load_store();
    test_branch();
    test_trap();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
